// File: rtl/usb_pkg.sv
// Shared USB receive-side definitions: PID encodings, checker states,
// CRC seeds/residuals/tap masks and packet length limits.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_e;

  typedef enum logic [1:0] {
    PC_TOKEN = 2'd0,
    PC_DATA  = 2'd1,
    PC_HAND  = 2'd2,
    PC_BAD   = 2'd3
  } pid_class_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CRC5  = 3'd1,
    S_CRC16 = 3'd2,
    S_NOCRC = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [4:0]  CRC5_SEED   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'b01100;
  localparam logic [4:0]  CRC5_TAPS   = 5'b00101;
  localparam logic [15:0] CRC16_SEED  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;
  localparam logic [15:0] CRC16_TAPS  = 16'h8005;

  localparam logic [10:0] CRC5_BITS      = 11'd16;
  localparam logic [10:0] CRC16_MIN_BITS = 11'd16;
  localparam logic [10:0] MAX_BITS       = 11'd1040;
  localparam logic [10:0] CNT_MAX        = 11'd2047;

  function automatic pid_class_e pid_class(input logic [3:0] pid);
    pid_class_e c;
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: c = PC_TOKEN;
      PID_DATA0, PID_DATA1:                c = PC_DATA;
      PID_ACK, PID_NAK, PID_STALL:         c = PC_HAND;
      default:                             c = PC_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/crc_shift.sv
// Bit-serial Galois LFSR: feedback = msb ^ din, shifted up and XORed into
// every bit set in TAPS. crc_nxt exposes the value after the current bit.
module crc_shift #(
  parameter int             W    = 5,
  parameter logic [W-1:0]   TAPS = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] seed,
  input  logic         load,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] crc_nxt
);

  logic [W-1:0] r_crc;
  logic         w_fb;
  logic [W-1:0] w_shifted;

  always_comb begin
    w_fb      = r_crc[W-1] ^ din;
    w_shifted = {r_crc[W-2:0], 1'b0} ^ (w_fb ? TAPS : {W{1'b0}});
    if (shift_en) begin
      crc_nxt = w_shifted;
    end else begin
      crc_nxt = r_crc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_crc <= {W{1'b0}};
    end else if (load) begin
      r_crc <= seed;
    end else if (shift_en) begin
      r_crc <= w_shifted;
    end else begin
      r_crc <= r_crc;
    end
  end

endmodule

// File: rtl/crc_check.sv
// USB packet CRC/length checker: classifies the PID on start, runs CRC5 or
// CRC16 over the field bits, and issues a one-cycle verdict after eop.
module crc_check
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic [3:0] pktType,
  input  logic       bit_valid,
  input  logic       bstr,
  input  logic       eop,
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic       crc_err,
  output logic       len_err,
  output logic       pid_err
);

  state_e      r_state, w_state_nxt;
  logic [10:0] r_cnt, w_cnt_nxt;
  logic        r_busy, r_done, r_ok, r_err, r_len, r_pid;
  logic        w_ok_nxt, w_err_nxt, w_len_nxt, w_pid_nxt;
  logic        w_busy, w_shift5, w_shift16, w_len16_ok;
  logic [4:0]  w_crc5_nxt;
  logic [15:0] w_crc16_nxt;

  assign w_busy    = (r_state == S_CRC5) || (r_state == S_CRC16) || (r_state == S_NOCRC);
  assign w_shift5  = !start && bit_valid && (r_state == S_CRC5);
  assign w_shift16 = !start && bit_valid && (r_state == S_CRC16);

  crc_shift #(.W(5), .TAPS(CRC5_TAPS)) u_crc5 (
    .clk      (clk),
    .rst_b    (rst_b),
    .seed     (CRC5_SEED),
    .load     (start),
    .shift_en (w_shift5),
    .din      (bstr),
    .crc_nxt  (w_crc5_nxt)
  );

  crc_shift #(.W(16), .TAPS(CRC16_TAPS)) u_crc16 (
    .clk      (clk),
    .rst_b    (rst_b),
    .seed     (CRC16_SEED),
    .load     (start),
    .shift_en (w_shift16),
    .din      (bstr),
    .crc_nxt  (w_crc16_nxt)
  );

  // Bit count including a bit that arrives together with eop, so the verdict sees it.
  always_comb begin
    if (start) begin
      w_cnt_nxt = 11'd0;
    end else if (w_busy && bit_valid) begin
      w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + 11'd1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
    w_len16_ok = (w_cnt_nxt[2:0] == 3'd0) && (w_cnt_nxt >= CRC16_MIN_BITS) &&
                 (w_cnt_nxt <= MAX_BITS);
  end

  // Next state and verdict; start overrides eop and everything else.
  always_comb begin
    w_state_nxt = r_state;
    w_ok_nxt    = r_ok;
    w_err_nxt   = r_err;
    w_len_nxt   = r_len;
    w_pid_nxt   = r_pid;
    if (start) begin
      w_ok_nxt  = 1'b0;
      w_err_nxt = 1'b0;
      w_len_nxt = 1'b0;
      w_pid_nxt = 1'b0;
      case (pid_class(pktType))
        PC_TOKEN: w_state_nxt = S_CRC5;
        PC_DATA:  w_state_nxt = S_CRC16;
        PC_HAND:  w_state_nxt = S_NOCRC;
        default: begin
          w_state_nxt = S_DONE;
          w_pid_nxt   = 1'b1;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_CRC5: begin
          if (eop) begin
            w_state_nxt = S_DONE;
            if (w_cnt_nxt != CRC5_BITS) begin
              w_len_nxt = 1'b1;
            end else if (w_crc5_nxt == CRC5_RESID) begin
              w_ok_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = S_CRC5;
          end
        end
        S_CRC16: begin
          if (eop) begin
            w_state_nxt = S_DONE;
            if (!w_len16_ok) begin
              w_len_nxt = 1'b1;
            end else if (w_crc16_nxt == CRC16_RESID) begin
              w_ok_nxt = 1'b1;
            end else begin
              w_err_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = S_CRC16;
          end
        end
        S_NOCRC: begin
          if (eop) begin
            w_state_nxt = S_DONE;
            if (w_cnt_nxt != 11'd0) begin
              w_len_nxt = 1'b1;
            end else begin
              w_ok_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = S_NOCRC;
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State, count and registered outputs; busy/done are decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
      r_cnt   <= 11'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_len   <= 1'b0;
      r_pid   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == S_CRC5) || (w_state_nxt == S_CRC16) ||
                 (w_state_nxt == S_NOCRC);
      r_done  <= (w_state_nxt == S_DONE);
      r_ok    <= w_ok_nxt;
      r_err   <= w_err_nxt;
      r_len   <= w_len_nxt;
      r_pid   <= w_pid_nxt;
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign crc_ok  = r_ok;
  assign crc_err = r_err;
  assign len_err = r_len;
  assign pid_err = r_pid;

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: table of packets with expected verdicts,
// a verdict scoreboard popped on every done, plus hand-written corner sequences.
module tb_crc_check;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic [3:0] pktType = 4'd0;
  logic       bit_valid = 1'b0;
  logic       bstr = 1'b0;
  logic       eop = 1'b0;
  logic       busy, done, crc_ok, crc_err, len_err, pid_err;

  int n_tests = 0;
  int n_fail  = 0;

  // verdict encoding {crc_ok, crc_err, len_err, pid_err}
  localparam logic [3:0] V_OK  = 4'b1000;
  localparam logic [3:0] V_ERR = 4'b0100;
  localparam logic [3:0] V_LEN = 4'b0010;
  localparam logic [3:0] V_PID = 4'b0001;

  typedef struct {
    logic [3:0]  pid;
    logic [63:0] data;
    int          nbits;
    logic        merge;
    logic [3:0]  exp;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];

  crc_check dut (
    .clk(clk), .rst_b(rst_b), .start(start), .pktType(pktType),
    .bit_valid(bit_valid), .bstr(bstr), .eop(eop), .busy(busy), .done(done),
    .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err), .pid_err(pid_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge, and score any done pulse.
  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        e = sb.pop_front();
        chk("verdict", 32'({crc_ok, crc_err, len_err, pid_err}), 32'(e));
      end
    end
  endtask

  // Reflected CRC5 (poly 0x14), independent of the DUT's LFSR orientation.
  function automatic logic [4:0] crc5_ref(input logic [10:0] f);
    logic [4:0] c = 5'h1F;
    for (int j = 0; j < 11; j++) begin
      if (c[0] ^ f[j]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    end
    return ~c;
  endfunction

  // Reflected CRC-16/USB (poly 0xA001) over four bytes, low byte first.
  function automatic logic [15:0] crc16_ref(input logic [31:0] b);
    logic [15:0] c = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      c = c ^ {8'h00, b[8*k +: 8]};
      for (int j = 0; j < 8; j++) begin
        if (c[0]) c = (c >> 1) ^ 16'hA001;
        else      c = c >> 1;
      end
    end
    return ~c;
  endfunction

  task automatic shift_bits(input logic [1047:0] d, input int nbits, input logic merge);
    for (int i = 0; i < nbits; i++) begin
      bit_valid = 1'b1;
      bstr      = d[i];
      eop       = merge && (i == nbits - 1);
      tick();
    end
    bit_valid = 1'b0;
    bstr      = 1'b0;
    if (!(merge && nbits > 0)) begin
      eop = 1'b1;
      tick();
    end
    eop = 1'b0;
    chk("done_after_eop", 32'(done), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    tick();
    chk("done_one_cycle", 32'({done, busy}), 32'd0);
  endtask

  task automatic send(input logic [3:0] pid, input logic [1047:0] d, input int nbits,
                      input logic merge, input logic [3:0] exp);
    sb.push_back(exp);
    start   = 1'b1;
    pktType = pid;
    tick();
    start = 1'b0;
    chk("busy_open", 32'({busy, done}), 32'd2);
    shift_bits(d, nbits, merge);
  endtask

  initial begin
    logic [10:0] f;
    logic [31:0] b;
    logic [63:0] d64;

    vecs.push_back('{4'b1101, 64'h1000, 16, 1'b0, V_OK});
    vecs.push_back('{4'b1101, 64'h0000, 16, 1'b1, V_ERR});
    vecs.push_back('{4'b0011, 64'h0000, 16, 1'b0, V_OK});
    vecs.push_back('{4'b0011, 64'h0000, 15, 1'b0, V_LEN});
    vecs.push_back('{4'b0010, 64'h0000, 0,  1'b0, V_OK});
    vecs.push_back('{4'b0010, 64'h0000, 8,  1'b0, V_LEN});
    vecs.push_back('{4'b0001, 64'h1000, 15, 1'b0, V_LEN});
    vecs.push_back('{4'b1011, 64'h0000, 24, 1'b1, V_ERR});
    vecs.push_back('{4'b1110, 64'h0000, 0,  1'b0, V_OK});
    for (int r = 0; r < 3; r++) begin
      f   = 11'($urandom);
      d64 = {48'd0, crc5_ref(f), f};
      vecs.push_back('{4'b1001, d64, 16, 1'(r & 1), V_OK});
      b   = $urandom;
      d64 = {16'd0, crc16_ref(b), b};
      vecs.push_back('{4'b0011, d64, 48, 1'(r & 1), V_OK});
      d64[r + 3] = ~d64[r + 3];
      vecs.push_back('{4'b1011, d64, 48, 1'b0, V_ERR});
    end

    tick();
    tick();
    chk("reset_outputs", 32'({busy, done, crc_ok, crc_err, len_err, pid_err}), 32'd0);
    rst_b = 1'b1;
    bit_valid = 1'b1;
    eop = 1'b1;
    tick();
    tick();
    bit_valid = 1'b0;
    eop = 1'b0;
    chk("idle_ignores_inputs", 32'({busy, done}), 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i].pid, {984'd0, vecs[i].data}, vecs[i].nbits, vecs[i].merge, vecs[i].exp);
    end

    // CRC16 length boundaries at the 1040-bit ceiling
    send(4'b0011, '0, 1040, 1'b0, V_ERR);
    send(4'b0011, '0, 1048, 1'b0, V_LEN);
    send(4'b0011, '0, 1041, 1'b0, V_LEN);

    // Illegal PIDs: verdict on the cycle after start, no eop needed
    for (int p = 0; p < 2; p++) begin
      sb.push_back(V_PID);
      start   = 1'b1;
      pktType = (p == 0) ? 4'b0111 : 4'b0000;
      tick();
      start = 1'b0;
      chk("pid_done_next_cycle", 32'(sb.size()), 32'd0);
      tick();
      chk("pid_err_held", 32'({done, busy, pid_err}), 32'd1);
    end

    // start together with eop: eop is dropped, packet proceeds normally
    sb.push_back(V_OK);
    start   = 1'b1;
    eop     = 1'b1;
    pktType = 4'b0001;
    tick();
    start = 1'b0;
    eop   = 1'b0;
    chk("start_beats_eop", 32'({busy, done}), 32'd2);
    shift_bits(1048'h1000, 16, 1'b0);

    // Restart after 5 bits of a token: only the second packet reports
    start   = 1'b1;
    pktType = 4'b1101;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bstr      = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    send(4'b1101, 1048'h1000, 16, 1'b0, V_OK);
    tick();
    chk("verdict_held", 32'({crc_ok, done}), 32'd2);

    // Reset in the middle of a data packet
    start   = 1'b1;
    pktType = 4'b0011;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_valid = 1'b1;
      bstr      = i[0];
      tick();
    end
    rst_b = 1'b0;
    tick();
    chk("midpkt_reset", 32'({busy, done, crc_ok, crc_err, len_err, pid_err}), 32'd0);
    rst_b = 1'b1;
    eop   = 1'b1;
    tick();
    tick();
    tick();
    bit_valid = 1'b0;
    eop       = 1'b0;
    chk("post_reset_quiet", 32'({busy, done, crc_ok, crc_err, len_err, pid_err}), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_check.md
CRC_CHECK -- requirements
Module: crc_check

Interface
REQ-001 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 Port rst_b  in  1  reset; synchronous, active-low.
REQ-003 Port start  in  1  one-cycle pulse opening a packet; samples pktType.
REQ-004 Port pktType  in  4  PID type nibble; meaningful only when start=1.
REQ-005 Port bit_valid  in  1  bstr carries a received, unstuffed field bit this cycle.
REQ-006 Port bstr  in  1  serial field bit after the PID, LSB-first per byte, CRC bits included.
REQ-007 Port eop  in  1  one-cycle pulse closing the packet.
REQ-008 Port busy  out  1  packet open (CRC5, CRC16 or NOCRC state).
REQ-009 Port done  out  1  one-cycle pulse: verdict valid.
REQ-010 Port crc_ok  out  1  packet accepted; held until next start or reset.
REQ-011 Port crc_err  out  1  CRC residual mismatch; held as crc_ok.
REQ-012 Port len_err  out  1  bit count illegal for pktType; held as crc_ok.
REQ-013 Port pid_err  out  1  pktType not token, data or handshake; held as crc_ok.

Function
REQ-014 States SHALL be IDLE, CRC5, CRC16, NOCRC and DONE.
REQ-015 start in any state SHALL seed CRC5 to 5'h1F and CRC16 to 16'hFFFF, clear the bit count and all verdict outputs, and go to: CRC5 for pktType 0001/1001/0101/1101; CRC16 for 0011/1011; NOCRC for 0010/1010/1110; DONE with pid_err=1 otherwise.
REQ-016 start while busy SHALL abort the open packet with no done for it.
REQ-017 Each bit_valid in CRC5/CRC16 SHALL advance the selected LFSR once: fb = msb ^ bstr; shift up, fb into bit 0, also XORed into bit 2 (CRC5, x^5+x^2+1) or bits 2 and 15 (CRC16, x^16+x^15+x^2+1).
REQ-018 Each bit_valid in any busy state SHALL increment an 11-bit bit count, saturating at 2047.
REQ-019 bit_valid, bstr and eop SHALL be ignored in IDLE and DONE.
REQ-020 eop in a busy state SHALL move to DONE; a bit_valid in the same cycle SHALL be included before evaluation.
REQ-021 In DONE, done=1 for exactly one cycle, then IDLE; done SHALL follow eop by one cycle.
REQ-022 Length rules: CRC5 exactly 16 bits; CRC16 a multiple of 8 in 16..1040 bits; NOCRC 0 bits; a violation SHALL set len_err only.
REQ-023 With legal length: CRC5 residual 5'b01100 or CRC16 residual 16'h800D SHALL set crc_ok, otherwise crc_err; NOCRC SHALL set crc_ok.
REQ-024 Exactly one of crc_ok, crc_err, len_err, pid_err SHALL be 1 while done=1.
REQ-025 start and eop in the same cycle SHALL be treated as start, and eop SHALL be ignored.

Reset
REQ-026 rst_b=0 at a clock edge SHALL force IDLE, clear both LFSRs and the bit count, and drive busy, done, crc_ok, crc_err, len_err and pid_err to 0, including mid-packet, with no done issued.

Structure
REQ-027 Package usb_pkg SHALL hold the PID-type enum, CRC5/CRC16 seeds and residuals, and the 1040-bit maximum.
REQ-028 The bit-serial LFSR SHALL be a sub-module crc_shift, parameterized by width and tap mask, with inputs seed/load/shift_en; two instances.

Verification
REQ-029 start, pktType=1101, bytes 0x00,0x10 LSB-first (16 bits), eop -> done one cycle later with crc_ok=1.
REQ-030 Same as REQ-029 with bit 12 inverted -> crc_err=1, crc_ok=0.
REQ-031 start, pktType=0011, bytes 0x00,0x00, eop -> crc_ok; same with 15 bits -> len_err=1.
REQ-032 start, pktType=0010, eop with 0 bits -> crc_ok; with 8 bits -> len_err; start with pktType=0111 -> pid_err and done on the next cycle.
REQ-033 Restart after 5 bits of a token, then a valid token -> exactly one done, crc_ok=1; rst_b=0 mid-packet -> all outputs 0, no done.
